// File: rtl/hex_display_scanner_if.sv
// Display-side bundle of the hex scanner: value/load in, decoder nibble,
// digit enables and frame pulse out, plus pending/display state for observation.
interface hex_display_scanner_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] value;
   logic                load;
   logic [3:0]          num;
   logic [DIGITS-1:0]   digit_en;
   logic                frame;
   logic                pend_flag;
   logic [4*DIGITS-1:0] disp;

   // load is a single-cycle strobe with no ready: the scanner accepts every load.
   modport master (
      output value, load,
      input  num, digit_en, frame, pend_flag, disp
   );

   modport slave (
      input  value, load,
      output num, digit_en, frame, pend_flag, disp
   );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 7-segment scan controller: steps through DIGITS nibbles,
// with loads held pending until the frame wraps so a frame never tears.
module hex_display_scanner #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_LZ    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   hex_display_scanner_if.slave bus
);
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0] disp_q, disp_d;
   logic [4*DIGITS-1:0] pend_q, pend_d;
   logic                pend_flag_q, pend_flag_d;
   logic [3:0]          num_q, num_d;
   logic [DIGITS-1:0]   en_q, en_d;
   logic                frame_q, frame_d;

   logic                tick, wrap, zero_above;
   logic [DIGITS-1:0]   blank;
   int                  idx_int;

   always_comb begin
      tick        = (presc_q == PRESC_MAX);
      wrap        = tick && (idx_q == IDX_MAX);
      presc_d     = tick ? '0 : presc_q + 1'b1;
      idx_d       = idx_q;
      disp_d      = disp_q;
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;
      idx_int     = int'(idx_q);

      if (tick) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end

      // A load landing on the wrap edge goes straight to the display and
      // supersedes anything still pending.
      if (wrap) begin
         if (bus.load) begin
            disp_d      = bus.value;
            pend_flag_d = 1'b0;
         end else if (pend_flag_q) begin
            disp_d      = pend_q;
            pend_flag_d = 1'b0;
         end
      end else if (bus.load) begin
         pend_d      = bus.value;
         pend_flag_d = 1'b1;
      end

      // Walk from the top digit down; a digit is blank only while every
      // nibble from it upward is zero. Digit 0 always stays lit.
      blank      = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         zero_above = zero_above && (disp_q[4*i +: 4] == 4'h0);
         blank[i]   = (BLANK_LZ != 0) && zero_above;
      end

      num_d   = disp_q[4*idx_int +: 4];
      en_d    = blank[idx_int] ? '1 : ~(DIGITS'(1) << idx_q);
      frame_d = wrap;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q     <= '0;
         idx_q       <= '0;
         disp_q      <= '0;
         pend_q      <= '0;
         pend_flag_q <= 1'b0;
         num_q       <= 4'h0;
         en_q        <= ~(DIGITS'(1));
         frame_q     <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         disp_q      <= disp_d;
         pend_q      <= pend_d;
         pend_flag_q <= pend_flag_d;
         num_q       <= num_d;
         en_q        <= en_d;
         frame_q     <= frame_d;
      end
   end

   assign bus.num       = num_q;
   assign bus.digit_en  = en_q;
   assign bus.frame     = frame_q;
   assign bus.pend_flag = pend_flag_q;
   assign bus.disp      = disp_q;
endmodule
